a51_keystream_core: RTL

- A5/1 keystream engine that sits directly downstream of the Wishbone register interface.
- The interface writes a 64-bit key and a 22-bit frame number, then pulses start.
- The core runs the three majority-clocked LFSRs through key load, frame load and mixing, then generates keystream.
- Keystream is packed into 32-bit words, delivered over a valid/ready handshake, and the register interface drains the words into its read data.

---
 rtl/a51_keystream_core_if.sv | 27 ++
 rtl/a51_keystream_core.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/a51_keystream_core_if.sv
// Request and keystream handshake between the Wishbone register block (master)
// and the A5/1 keystream core (slave).
// The abort signal exists only when A51_CORE_ABORT_EN is defined.
interface a51_keystream_core_if;
    logic        start;
    logic [63:0] key;
    logic [21:0] frame;
    logic        busy;
    logic        done;
    logic [31:0] ks_data;
    logic        ks_valid;
    logic        ks_ready;
    logic        ks_last;
`ifdef A51_CORE_ABORT_EN
    logic        abort;

    modport master (output start, key, frame, ks_ready, abort,
                    input  busy, done, ks_data, ks_valid, ks_last);
    modport slave  (input  start, key, frame, ks_ready, abort,
                    output busy, done, ks_data, ks_valid, ks_last);
`else
    modport master (output start, key, frame, ks_ready,
                    input  busy, done, ks_data, ks_valid, ks_last);
    modport slave  (input  start, key, frame, ks_ready,
                    output busy, done, ks_data, ks_valid, ks_last);
`endif
endinterface

// File: rtl/a51_keystream_core.sv
// A5/1 keystream engine.
// The core loads the key and the frame number into three LFSRs and runs a
// majority-clocked mix. It then packs the keystream MSB-first into 32-bit
// words and delivers them over a valid/ready handshake.
// Optional feature: define A51_CORE_ABORT_EN to add the abort input.
module a51_keystream_core #(
    parameter int KS_BITS    = 228,
    parameter int MIX_CYCLES = 100
) (
    input  logic                clk,
    input  logic                reset,
    a51_keystream_core_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_KEY, S_FRAME, S_MIX, S_GEN, S_DRAIN
    } state_t;

    localparam logic [9:0] KS_LAST  = 10'(KS_BITS - 1);
    localparam logic [9:0] MIX_LAST = 10'(MIX_CYCLES - 1);

    state_t      state_q, state_d;
    logic [18:0] r1_q, r1_d, r1_m;
    logic [21:0] r2_q, r2_d, r2_m;
    logic [22:0] r3_q, r3_d, r3_m;
    logic [9:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] ks_data_q, ks_data_d;
    logic        ks_valid_q, ks_valid_d;
    logic        ks_last_q, ks_last_d;

    logic        maj, out_m, inj, word_end, last_bit, accept, gen_fire, abort_req;
    logic [31:0] word;

    function automatic logic [18:0] step_r1(input logic [18:0] r);
        return {r[17:0], r[13] ^ r[16] ^ r[17] ^ r[18]};
    endfunction

    function automatic logic [21:0] step_r2(input logic [21:0] r);
        return {r[20:0], r[20] ^ r[21]};
    endfunction

    function automatic logic [22:0] step_r3(input logic [22:0] r);
        return {r[21:0], r[7] ^ r[20] ^ r[21] ^ r[22]};
    endfunction

`ifdef A51_CORE_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    // Majority-clocked step candidate and the output bit it produces
    always_comb begin
        maj   = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);
        r1_m  = (r1_q[8]  == maj) ? step_r1(r1_q) : r1_q;
        r2_m  = (r2_q[10] == maj) ? step_r2(r2_q) : r2_q;
        r3_m  = (r3_q[10] == maj) ? step_r3(r3_q) : r3_q;
        out_m = r1_m[18] ^ r2_m[21] ^ r3_m[22];
    end

    // Handshake qualifiers: GEN only advances when a finished word has somewhere to go
    always_comb begin
        accept   = ks_valid_q & bus.ks_ready;
        last_bit = (cnt_q == KS_LAST);
        word_end = (cnt_q[4:0] == 5'd31) | last_bit;
        gen_fire = (state_q == S_GEN) & (~word_end | ~ks_valid_q | bus.ks_ready);
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic; abort overrides everything including start
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start)             state_d = S_KEY;
            S_KEY:   if (cnt_q == 10'd63)       state_d = S_FRAME;
            S_FRAME: if (cnt_q == 10'd21)       state_d = S_MIX;
            S_MIX:   if (cnt_q == MIX_LAST)     state_d = S_GEN;
            S_GEN:   if (gen_fire && last_bit)  state_d = S_DRAIN;
            S_DRAIN: if (accept)                state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
        if (abort_req) state_d = S_IDLE;
    end

    // FSM outputs: busy from state, done on the final handshake
    always_comb begin
        bus.busy = (state_q != S_IDLE);
        bus.done = (state_q == S_DRAIN) & accept & ~abort_req;
    end

    assign bus.ks_data  = ks_data_q;
    assign bus.ks_valid = ks_valid_q;
    assign bus.ks_last  = ks_last_q;

    // Datapath next values: LFSR loading/stepping, counters and word packing
    always_comb begin
        r1_d       = r1_q;
        r2_d       = r2_q;
        r3_d       = r3_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        ks_data_d  = ks_data_q;
        ks_valid_d = ks_valid_q;
        ks_last_d  = ks_last_q;
        inj        = (state_q == S_KEY) ? bus.key[cnt_q[5:0]] : bus.frame[cnt_q[4:0]];
        word       = {acc_q[30:0], out_m};

        if (accept) begin
            ks_valid_d = 1'b0;
            ks_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    r1_d  = '0;
                    r2_d  = '0;
                    r3_d  = '0;
                    cnt_d = '0;
                    acc_d = '0;
                end
            end
            S_KEY, S_FRAME: begin
                r1_d = step_r1(r1_q) ^ {18'd0, inj};
                r2_d = step_r2(r2_q) ^ {21'd0, inj};
                r3_d = step_r3(r3_q) ^ {22'd0, inj};
                if ((state_q == S_KEY && cnt_q == 10'd63) || (state_q == S_FRAME && cnt_q == 10'd21))
                    cnt_d = '0;
                else
                    cnt_d = cnt_q + 10'd1;
            end
            S_MIX: begin
                r1_d  = r1_m;
                r2_d  = r2_m;
                r3_d  = r3_m;
                cnt_d = (cnt_q == MIX_LAST) ? 10'd0 : cnt_q + 10'd1;
            end
            S_GEN: begin
                if (gen_fire) begin
                    r1_d  = r1_m;
                    r2_d  = r2_m;
                    r3_d  = r3_m;
                    cnt_d = cnt_q + 10'd1;
                    if (word_end) begin
                        // Left-justify a short final word; a full word shifts by zero
                        ks_data_d  = word << (5'd31 - cnt_q[4:0]);
                        ks_valid_d = 1'b1;
                        ks_last_d  = last_bit;
                        acc_d      = '0;
                    end else begin
                        acc_d = word;
                    end
                end
            end
            default: ;
        endcase

        if (abort_req) begin
            ks_valid_d = 1'b0;
            ks_last_d  = 1'b0;
            acc_d      = '0;
            cnt_d      = '0;
        end
    end

    // Datapath registers, all cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_q       <= '0;
            r2_q       <= '0;
            r3_q       <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            ks_data_q  <= '0;
            ks_valid_q <= 1'b0;
            ks_last_q  <= 1'b0;
        end else begin
            r1_q       <= r1_d;
            r2_q       <= r2_d;
            r3_q       <= r3_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            ks_data_q  <= ks_data_d;
            ks_valid_q <= ks_valid_d;
            ks_last_q  <= ks_last_d;
        end
    end

endmodule
